maxpool_window_gen: RTL and testbench

- Streaming 3x3 window generator that feeds the max-pooling comparator tree.
- Accepts one FP32 feature-map pixel per Valid_In beat, in raster order (row-major, top-left first).
- Buffers two previous rows and emits a complete 3x3 window (nine parallel words plus Valid_Out) at every pooling-stride position.
- Sits between the convolution/activation output stream and the 3x3 max comparator.

---
 rtl/maxpool_window_gen.sv | 124 ++++++++++++
 tb/tb_maxpool_window_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_window_gen.sv
// Streaming 3x3 window generator for max pooling: two line buffers plus a
// 3x3 register window, emitting one window per stride position in raster order.
module maxpool_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int STRIDE     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out0,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    PH_LAST  = 2'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    col_ph;
    logic [1:0]    row_ph;

    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win [3][3];

    logic       col_ok;
    logic       row_ok;
    logic [1:0] col_ph_cur;
    logic [1:0] row_ph_cur;
    logic       col_end;
    logic       frame_end;
    logic       win_valid;

    function automatic logic [1:0] ph_next(input logic [1:0] p);
        return (p == PH_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // The phase is forced to zero at index 2 so each row/frame restarts the stride grid.
    always_comb begin
        col_ok     = (col >= CW'(2));
        row_ok     = (row >= RW'(2));
        col_ph_cur = (col == CW'(2)) ? 2'd0 : col_ph;
        row_ph_cur = (row == RW'(2)) ? 2'd0 : row_ph;
        col_end    = (col == COL_LAST);
        frame_end  = col_end && (row == ROW_LAST);
        win_valid  = col_ok && row_ok && (col_ph_cur == 2'd0) && (row_ph_cur == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= Valid_In && win_valid;
            Frame_Done <= Valid_In && frame_end;
            if (Valid_In) begin
                if (col_ok) col_ph <= ph_next(col_ph_cur);
                if (col_end) begin
                    col <= '0;
                    if (row_ok) row_ph <= ph_next(row_ph_cur);
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffers hold no reset: rows 0 and 1 of every frame refill them before use.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            lb1[col] <= lb0[col];
            lb0[col] <= Data_In;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (Valid_In) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= Data_In;
        end
    end

    assign Data_Out0 = win[0][0];
    assign Data_Out1 = win[0][1];
    assign Data_Out2 = win[0][2];
    assign Data_Out3 = win[1][0];
    assign Data_Out4 = win[1][1];
    assign Data_Out5 = win[1][2];
    assign Data_Out6 = win[2][0];
    assign Data_Out7 = win[2][1];
    assign Data_Out8 = win[2][2];

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Bench for maxpool_window_gen: three 5x5 instances (stride 2/1/3) share one
// stream, a 28x28 stride-2 instance gets random FP32 frames.
module tb_maxpool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s, vin_s, rst_b, vin_b;
    logic [31:0] din_s, din_b;
    logic [31:0] dout [4][9];
    logic        vout [4];
    logic        fdone [4];

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst_s), .Data_In(din_s), .Valid_In(vin_s),
        .Data_Out0(dout[0][0]), .Data_Out1(dout[0][1]), .Data_Out2(dout[0][2]),
        .Data_Out3(dout[0][3]), .Data_Out4(dout[0][4]), .Data_Out5(dout[0][5]),
        .Data_Out6(dout[0][6]), .Data_Out7(dout[0][7]), .Data_Out8(dout[0][8]),
        .Valid_Out(vout[0]), .Frame_Done(fdone[0]));

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(1)) u_s1 (
        .clk(clk), .rst(rst_s), .Data_In(din_s), .Valid_In(vin_s),
        .Data_Out0(dout[1][0]), .Data_Out1(dout[1][1]), .Data_Out2(dout[1][2]),
        .Data_Out3(dout[1][3]), .Data_Out4(dout[1][4]), .Data_Out5(dout[1][5]),
        .Data_Out6(dout[1][6]), .Data_Out7(dout[1][7]), .Data_Out8(dout[1][8]),
        .Valid_Out(vout[1]), .Frame_Done(fdone[1]));

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(3)) u_s3 (
        .clk(clk), .rst(rst_s), .Data_In(din_s), .Valid_In(vin_s),
        .Data_Out0(dout[2][0]), .Data_Out1(dout[2][1]), .Data_Out2(dout[2][2]),
        .Data_Out3(dout[2][3]), .Data_Out4(dout[2][4]), .Data_Out5(dout[2][5]),
        .Data_Out6(dout[2][6]), .Data_Out7(dout[2][7]), .Data_Out8(dout[2][8]),
        .Valid_Out(vout[2]), .Frame_Done(fdone[2]));

    maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(28), .IMG_HEIGHT(28), .STRIDE(2)) u_big (
        .clk(clk), .rst(rst_b), .Data_In(din_b), .Valid_In(vin_b),
        .Data_Out0(dout[3][0]), .Data_Out1(dout[3][1]), .Data_Out2(dout[3][2]),
        .Data_Out3(dout[3][3]), .Data_Out4(dout[3][4]), .Data_Out5(dout[3][5]),
        .Data_Out6(dout[3][6]), .Data_Out7(dout[3][7]), .Data_Out8(dout[3][8]),
        .Valid_Out(vout[3]), .Frame_Done(fdone[3]));

    // Reference model state: group 0 = 5x5 stream, group 1 = 28x28 stream.
    logic [31:0]  frm [2][0:783];
    logic [31:0]  hist [2][0:1023];
    int           pix [2];
    int           nb [2];
    logic [287:0] hold_win [2];
    bit           hold_ok [2];
    bit           exp_vo [4];
    bit           exp_fd [4];
    int           vcnt [4];
    int           fcnt [4];
    logic [287:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail = 0;

    function automatic int grp(input int id);
        return (id == 3) ? 1 : 0;
    endfunction

    function automatic int gw(input int g);
        return (g == 0) ? 5 : 28;
    endfunction

    function automatic int stride_of(input int id);
        case (id)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_windows(input int id);
        int w, s, n;
        w = gw(grp(id));
        s = stride_of(id);
        n = (w - 3) / s + 1;
        return n * n;
    endfunction

    function automatic logic [287:0] pack_out(input int id);
        logic [287:0] v;
        for (int k = 0; k < 9; k++) v[k*32 +: 32] = dout[id][k];
        return v;
    endfunction

    // Window whose bottom-right pixel is (r,c) of the current frame image.
    function automatic logic [287:0] frame_win(input int g, input int r, input int c);
        logic [287:0] v;
        int w;
        w = gw(g);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*32 +: 32] = frm[g][(r-2+i)*w + (c-2+j)];
        return v;
    endfunction

    // Window as a function of the raw stream: column from beat q = {q-2W, q-W, q}.
    function automatic logic [287:0] hist_win(input int g);
        logic [287:0] v;
        int w, n, q;
        w = gw(g);
        n = nb[g] - 1;
        for (int j = 0; j < 3; j++) begin
            q = n - 2 + j;
            v[j*32 +: 32]     = hist[g][q - 2*w];
            v[(3+j)*32 +: 32] = hist[g][q - w];
            v[(6+j)*32 +: 32] = hist[g][q];
        end
        return v;
    endfunction

    function automatic logic [287:0] first_ref(input int base);
        int lst [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        logic [287:0] v;
        for (int k = 0; k < 9; k++) v[k*32 +: 32] = 32'(base + lst[k]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [287:0] e;
        for (int id = 0; id < 4; id++) begin
            check($sformatf("valid_out[%0d]", id), 288'(vout[id]), 288'(exp_vo[id]));
            check($sformatf("frame_done[%0d]", id), 288'(fdone[id]), 288'(exp_fd[id]));
            if (vout[id]) vcnt[id]++;
            if (fdone[id]) fcnt[id]++;
            if (exp_vo[id]) begin
                e = exp_q.pop_front();
                check($sformatf("window[%0d]", id), pack_out(id), e);
            end
            if (hold_ok[grp(id)])
                check($sformatf("data_hold[%0d]", id), pack_out(id), hold_win[grp(id)]);
        end
    endtask

    task automatic step(input int g, input bit v, input logic [31:0] d);
        int w, p, r, c, s;
        if (g == 0) begin
            vin_s = v; din_s = d; vin_b = 1'b0;
        end else begin
            vin_b = v; din_b = d; vin_s = 1'b0;
        end
        for (int id = 0; id < 4; id++) begin
            exp_vo[id] = 1'b0;
            exp_fd[id] = 1'b0;
        end
        if (v) begin
            w = gw(g);
            p = pix[g];
            r = p / w;
            c = p % w;
            frm[g][p] = d;
            hist[g][nb[g]] = d;
            nb[g]++;
            for (int id = 0; id < 4; id++) begin
                if (grp(id) == g) begin
                    s = stride_of(id);
                    if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
                        exp_vo[id] = 1'b1;
                        exp_q.push_back(frame_win(g, r, c));
                    end
                    exp_fd[id] = (p == w * w - 1);
                end
            end
            pix[g] = (p + 1) % (w * w);
            if (nb[g] >= 2 * w + 3) begin
                hold_win[g] = hist_win(g);
                hold_ok[g] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int g);
        if (g == 0) rst_s = 1'b1; else rst_b = 1'b1;
        vin_s = 1'b0;
        vin_b = 1'b0;
        @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) begin
            if (grp(id) == g) begin
                check($sformatf("rst_valid_out[%0d]", id), 288'(vout[id]), 288'(0));
                check($sformatf("rst_frame_done[%0d]", id), 288'(fdone[id]), 288'(0));
                check($sformatf("rst_data_out[%0d]", id), pack_out(id), 288'(0));
            end
        end
        if (g == 0) rst_s = 1'b0; else rst_b = 1'b0;
        pix[g] = 0;
        nb[g] = 0;
        hold_ok[g] = 1'b0;
    endtask

    task automatic clear_counts();
        for (int id = 0; id < 4; id++) begin
            vcnt[id] = 0;
            fcnt[id] = 0;
        end
    endtask

    task automatic run_frame(input int g, input int base, input int gap_pct, input bit rnd);
        int w;
        w = gw(g);
        for (int p = 0; p < w * w; p++) begin
            while ($urandom_range(0, 99) < gap_pct) step(g, 1'b0, $urandom);
            step(g, 1'b1, rnd ? $urandom : 32'(base + p));
            if (g == 0 && p == 12)
                check($sformatf("first_window_base%0d", base), pack_out(0), first_ref(base));
        end
    endtask

    task automatic check_counts(input string tag, input int g, input int frames);
        for (int k = 0; k < 3; k++) step(g, 1'b0, $urandom);
        for (int id = 0; id < 4; id++) begin
            if (grp(id) == g) begin
                check($sformatf("%s_windows[%0d]", tag, id), 288'(vcnt[id]),
                      288'(frames * exp_windows(id)));
                check($sformatf("%s_frames[%0d]", tag, id), 288'(fcnt[id]), 288'(frames));
            end
        end
        clear_counts();
    endtask

    initial begin
        rst_s = 1'b1; rst_b = 1'b1;
        vin_s = 1'b0; vin_b = 1'b0;
        din_s = '0;   din_b = '0;
        for (int g = 0; g < 2; g++) begin
            pix[g] = 0; nb[g] = 0; hold_ok[g] = 1'b0; hold_win[g] = '0;
        end
        clear_counts();
        do_reset(0);
        do_reset(1);

        // Continuous single frame, pixel = index
        run_frame(0, 0, 0, 1'b0);
        check("last_window_s2", pack_out(0), hold_win[0]);
        check_counts("single", 0, 1);

        // Same frame with ~50% Valid_In gaps
        run_frame(0, 0, 50, 1'b0);
        check_counts("gaps", 0, 1);

        // Back-to-back frames
        run_frame(0, 0, 0, 1'b0);
        run_frame(0, 100, 0, 1'b0);
        check_counts("b2b", 0, 2);

        // Reset after 7 pixels, then a clean frame
        for (int p = 0; p < 7; p++) step(0, 1'b1, 32'(p));
        do_reset(0);
        clear_counts();
        run_frame(0, 0, 0, 1'b0);
        check_counts("after_rst", 0, 1);

        // Full-size frame, random FP32 words with some gaps
        run_frame(1, 0, 25, 1'b1);
        check_counts("big", 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
